// File: rtl/ls_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller: operation codes,
// bus types, FSM state encodings and the queued request record.
package ls_mem_ctrl_pkg;

   localparam logic READ_SIGNAL  = 1'b0;
   localparam logic WRITE_SIGNAL = 1'b1;

   localparam logic [31:0] NULL_PTR = 32'h0000_0000;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;
   typedef logic [7:0]  byte_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_RWAIT = 2'd2;
   localparam logic [1:0] ST_WRITE = 2'd3;

   // 73-bit queued request
   typedef struct packed {
      logic  oper;
      addr_t addr;
      byte_t size;
      word_t data;
   } ls_req_t;

   // Byte count from the low size bits: 0 means one byte, anything above 4 is four.
   function automatic logic [2:0] size_to_n(input logic [2:0] sz);
      if (sz == 3'd0)
         return 3'd1;
      else if (sz > 3'd4)
         return 3'd4;
      else
         return sz;
   endfunction

endpackage

// File: rtl/ls_mem_ctrl_if.sv
// Bus bundle between the LS execute unit / external RAM (master side) and
// the memory controller (slave side).
interface ls_mem_ctrl_if;
   import ls_mem_ctrl_pkg::*;

   // Handshake: a request is transferred at a posedge where en_ls=1, the FIFO
   // has room and in_fifo is low; in_fifo is then high for exactly one cycle,
   // and en_ls held during that cycle is treated as the same request.
   logic  rdy;
   logic  en_ls;
   logic  ls_oper;
   addr_t ls_addr;
   byte_t ls_size;
   word_t ls_data;
   logic  in_fifo;
   logic  finish;
   word_t ls_data_out;
   byte_t mem_din;
   byte_t mem_dout;
   addr_t mem_a;
   logic  mem_wr;
   logic  io_buffer_full;

   modport slave (
      input  rdy, en_ls, ls_oper, ls_addr, ls_size, ls_data, mem_din, io_buffer_full,
      output in_fifo, finish, ls_data_out, mem_dout, mem_a, mem_wr
   );

   modport master (
      output rdy, en_ls, ls_oper, ls_addr, ls_size, ls_data, mem_din, io_buffer_full,
      input  in_fifo, finish, ls_data_out, mem_dout, mem_a, mem_wr
   );

endinterface

// File: rtl/ls_mem_ctrl_req_fifo.sv
// In-order circular request FIFO (module ls_req_fifo); head entry is always
// visible on dout_o while not empty.
module ls_req_fifo
   import ls_mem_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push_i,
   input  logic    pop_i,
   input  ls_req_t din_i,
   output ls_req_t dout_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   ls_req_t       mem_q [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [PW:0]   count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[head_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + 1'b1;
         if (do_pop)  head_q <= head_q + 1'b1;
         if (do_push && !do_pop)
            count_q <= count_q + 1'b1;
         else if (!do_push && do_pop)
            count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= din_i;
   end

endmodule

// File: rtl/ls_mem_ctrl.sv
// Load/store responder: queues requests and serialises them into byte accesses
// on the 8-bit RAM port. Optional macro IO_STALL_EN stalls writes to IO_ADDR.
module ls_mem_ctrl
   import ls_mem_ctrl_pkg::*;
#(
   parameter int    DEPTH   = 4,
   parameter addr_t IO_ADDR = 32'h0003_0000
) (
   input  logic            clk,
   input  logic            rst,
   ls_mem_ctrl_if.slave    bus,
   output logic [1:0]      dbg_state_o
);

   ls_req_t     head;
   logic        full, empty, push, pop, stall, last;
   logic [1:0]  state_q, state_d, idx_q, idx_d;
   logic [2:0]  n_q, n_d;
   addr_t       addr_q, addr_d, cur_addr;
   word_t       data_q, data_d, dout_q, dout_d;
   logic [23:0] acc_q, acc_d;
   logic        in_fifo_q, finish_q, finish_d;
   logic        unused_size;

   assign push = bus.en_ls & ~full & ~in_fifo_q;

   ls_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push & bus.rdy),
      .pop_i   (pop & bus.rdy),
      .din_i   ({bus.ls_oper, bus.ls_addr, bus.ls_size, bus.ls_data}),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign unused_size = ^head.size[7:3];
   assign cur_addr    = addr_q + {30'd0, idx_q};
   assign last        = ({1'b0, idx_q} == (n_q - 3'd1));

`ifdef IO_STALL_EN
   assign stall = (state_q == ST_WRITE) && (cur_addr == IO_ADDR) && bus.io_buffer_full;
`else
   logic unused_io;
   assign unused_io = ^{bus.io_buffer_full, IO_ADDR};
   assign stall     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      n_d      = n_q;
      addr_d   = addr_q;
      data_d   = data_q;
      acc_d    = acc_q;
      dout_d   = dout_q;
      finish_d = 1'b0;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               addr_d  = head.addr;
               data_d  = head.data;
               n_d     = size_to_n(head.size[2:0]);
               idx_d   = 2'd0;
               acc_d   = '0;
               state_d = (head.oper == WRITE_SIGNAL) ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            // RAM data lags the address by one cycle, so byte i-1 arrives while index i is driven
            if (idx_q != 2'd0) acc_d = {acc_q[15:0], bus.mem_din};
            if (last) state_d = ST_RWAIT;
            else      idx_d   = idx_q + 2'd1;
         end
         ST_RWAIT: begin
            dout_d   = {acc_q, bus.mem_din};
            finish_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            if (!stall) begin
               if (last) state_d = ST_IDLE;
               else      idx_d   = idx_q + 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= 2'd0;
         n_q       <= 3'd1;
         addr_q    <= NULL_PTR;
         data_q    <= '0;
         acc_q     <= '0;
         dout_q    <= '0;
         finish_q  <= 1'b0;
         in_fifo_q <= 1'b0;
      end else if (bus.rdy) begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         acc_q     <= acc_d;
         dout_q    <= dout_d;
         finish_q  <= finish_d;
         in_fifo_q <= push;
      end
   end

   always_comb begin
      bus.mem_a    = NULL_PTR;
      bus.mem_dout = 8'h00;
      bus.mem_wr   = 1'b0;
      if (state_q == ST_READ) begin
         bus.mem_a = cur_addr;
      end else if (state_q == ST_WRITE) begin
         bus.mem_a    = cur_addr;
         bus.mem_dout = data_q[{idx_q, 3'b000} +: 8];
         bus.mem_wr   = ~stall;
      end
   end

   assign bus.in_fifo     = in_fifo_q;
   assign bus.finish      = finish_q;
   assign bus.ls_data_out = dout_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Directed bench for ls_mem_ctrl with a byte-wide RAM model and a write log.
module tb_ls_mem_ctrl;
  import ls_mem_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  ls_mem_ctrl_if bus();

  ls_mem_ctrl #(.DEPTH(4), .IO_ADDR(32'h0003_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_infifo = 0;
  int n_finish = 0;
  int pop_cyc = 0;
  logic [1:0] prev_state = ST_IDLE;
  logic [39:0] wr_log[$];
  int wr_cyc[$];
  logic [39:0] exp_q[$];
  logic [7:0] mem [logic [31:0]];

  // synchronous-read RAM model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_din <= mem.exists(bus.mem_a) ? mem[bus.mem_a] : 8'h00;
  end

  // monitor
  always @(negedge clk) begin
    if (bus.in_fifo === 1'b1) n_infifo++;
    if (bus.finish === 1'b1) n_finish++;
    if (bus.mem_wr === 1'b1) begin
      wr_log.push_back({bus.mem_a, bus.mem_dout});
      wr_cyc.push_back(cyc);
      mem[bus.mem_a] = bus.mem_dout;
    end
    if (prev_state == ST_IDLE && dbg_state != ST_IDLE) pop_cyc = cyc - 1;
    prev_state = dbg_state;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: hold en_ls until in_fifo is seen; returns negedges waited and accept cycle
  task automatic issue(input logic op, input logic [31:0] a, input logic [7:0] sz,
                       input logic [31:0] d, output int waits, output int acc_cyc);
    bus.ls_oper = op;
    bus.ls_addr = a;
    bus.ls_size = sz;
    bus.ls_data = d;
    bus.en_ls = 1'b1;
    waits = 0;
    while (waits < 100) begin
      @(negedge clk);
      waits++;
      if (bus.in_fifo === 1'b1) break;
    end
    acc_cyc = cyc;
    chk("issue_accepted", {31'd0, bus.in_fifo}, 32'd1);
    bus.en_ls = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [7:0] sz, input logic [31:0] exp_d,
                      input int exp_lat, input string tag, output logic [31:0] got);
    int w, c, t;
    issue(READ_SIGNAL, a, sz, 32'h0, w, c);
    t = 0;
    while (t < 30) begin
      @(negedge clk);
      t++;
      if (bus.finish === 1'b1) break;
    end
    got = bus.ls_data_out;
    chk({tag, "_finish"}, {31'd0, bus.finish}, 32'd1);
    chk({tag, "_data"}, bus.ls_data_out, exp_d);
    chk({tag, "_latency"}, cyc - c, exp_lat);
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_count"}, wr_log.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j < wr_log.size()) begin
        chk({tag, "_addr"}, wr_log[j][39:8], exp_q[j][39:8]);
        chk({tag, "_byte"}, {24'd0, wr_log[j][7:0]}, {24'd0, exp_q[j][7:0]});
      end
    end
  endtask

  initial begin
    int w, c, w7, c7, nf, ni;
    logic [31:0] got;

    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.en_ls = 1'b0;
    bus.ls_oper = READ_SIGNAL;
    bus.ls_addr = '0;
    bus.ls_size = '0;
    bus.ls_data = '0;
    bus.io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_fifo", {31'd0, bus.in_fifo}, 32'd0);
    chk("rst_finish", {31'd0, bus.finish}, 32'd0);
    chk("rst_data_out", bus.ls_data_out, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);

    // SW 0x100 <= 0x11223344
    wr_log.delete(); wr_cyc.delete(); exp_q.delete();
    nf = n_finish; ni = n_infifo;
    issue(WRITE_SIGNAL, 32'h100, 8'd4, 32'h1122_3344, w, c);
    repeat (8) @(negedge clk);
    #1;
    exp_q.push_back({32'h100, 8'h44});
    exp_q.push_back({32'h101, 8'h33});
    exp_q.push_back({32'h102, 8'h22});
    exp_q.push_back({32'h103, 8'h11});
    cmp_writes("sw");
    chk("sw_in_fifo_pulses", n_infifo - ni, 32'd1);
    chk("sw_no_finish", n_finish - nf, 32'd0);
    if (wr_cyc.size() == 4) begin
      chk("sw_first_wr_cycle", wr_cyc[0] - c, 32'd1);
      chk("sw_last_wr_cycle", wr_cyc[3] - c, 32'd4);
    end

    // loads
    load(32'h100, 8'd4, 32'h4433_2211, 6, "lw", got);
    chk("lw_swapped", {got[7:0], got[15:8], got[23:16], got[31:24]}, 32'h1122_3344);
    load(32'h103, 8'd1, 32'h0000_0011, 3, "lb", got);
    load(32'h102, 8'd2, 32'h0000_2211, 4, "lh", got);
    load(32'h100, 8'd7, 32'h4433_2211, 6, "size7_clamp", got);
    load(32'h101, 8'd0, 32'h0000_0033, 3, "size0_one", got);
    repeat (3) @(negedge clk);

    // back-to-back stores until the FIFO fills; the 8th waits for a pop
    wr_log.delete(); wr_cyc.delete(); exp_q.delete();
    ni = n_infifo;
    w7 = 0; c7 = 0;
    for (int k = 0; k < 8; k++) begin
      issue(WRITE_SIGNAL, 32'h200 + 32'(16 * k), 8'd4, 32'hA0B0_C000 | 32'(k), w, c);
      exp_q.push_back({32'h200 + 32'(16 * k), 8'(k)});
      exp_q.push_back({32'h201 + 32'(16 * k), 8'hC0});
      exp_q.push_back({32'h202 + 32'(16 * k), 8'hB0});
      exp_q.push_back({32'h203 + 32'(16 * k), 8'hA0});
      if (k == 7) begin
        w7 = w;
        c7 = c;
      end
    end
    chk("full_blocked", {31'd0, (w7 >= 3)}, 32'd1);
    chk("full_pop_to_ack", c7 - pop_cyc, 32'd2);
    repeat (60) @(negedge clk);
    #1;
    chk("full_in_fifo_pulses", n_infifo - ni, 32'd8);
    cmp_writes("full");

    // reset while READ drives byte 2
    issue(READ_SIGNAL, 32'h100, 8'd4, 32'h0, w, c);
    repeat (3) @(negedge clk);
    chk("mid_read_addr", bus.mem_a, 32'h102);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_fifo", {31'd0, bus.in_fifo}, 32'd0);
    chk("mid_rst_finish", {31'd0, bus.finish}, 32'd0);
    chk("mid_rst_data_out", bus.ls_data_out, 32'd0);
    chk("mid_rst_mem_a", bus.mem_a, 32'd0);
    chk("mid_rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("mid_rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    nf = n_finish;
    repeat (12) @(negedge clk);
    #1;
    chk("mid_rst_no_finish", n_finish - nf, 32'd0);
    chk("mid_rst_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    load(32'h101, 8'd1, 32'h0000_0033, 3, "post_rst_lb", got);

`ifdef IO_STALL_EN
    repeat (3) @(negedge clk);
    wr_log.delete(); wr_cyc.delete(); exp_q.delete();
    bus.io_buffer_full = 1'b1;
    issue(WRITE_SIGNAL, 32'h0003_0000, 8'd1, 32'h0000_005A, w, c);
    repeat (5) @(negedge clk);
    #1;
    chk("stall_no_write", wr_log.size(), 32'd0);
    chk("stall_state", {30'd0, dbg_state}, {30'd0, ST_WRITE});
    @(posedge clk);
    #1;
    bus.io_buffer_full = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    exp_q.push_back({32'h0003_0000, 8'h5A});
    cmp_writes("stall");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
